// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: parity modes, receiver
// state encoding and the fractional baud increment.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  // round(baud * oversample * 2^acc_width / clk_hz)
  function automatic longint baud_inc(input longint clk_hz, input longint baud,
                                      input longint oversample, input int acc_width);
    return (baud * oversample * (longint'(1) << acc_width) + clk_hz / 2) / clk_hz;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud accumulator: emits a one-clock tick on each carry out of the
// top accumulator bit; the carry is discarded before the next add.
module uart_baud_tick #(
  parameter int                   ACC_WIDTH = 18,
  parameter logic [ACC_WIDTH-1:0] INC       = '0
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, INC};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= sum[ACC_WIDTH-1:0];
      tick <= sum[ACC_WIDTH];
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised serial receiver with hysteresis filtering, false-start rejection,
// parity/framing/break flags and an inter-packet idle gap detector.
//   IDLE: line idle | START: validating start bit | DATA: shifting data bits
//   PARITY: sampling parity bit | STOP: sampling stop bit(s) | WAIT_HIGH: line held low after framing error
module uart_rx_param #(
  parameter int CLK_HZ      = 80000000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 8,
  parameter int ACC_WIDTH   = 18,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SAMPLE_TICK = OVERSAMPLE / 2 + 2,
  parameter int GAP_BITS    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic                 data_ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 endofpacket,
  output logic                 idle
);
  import uart_pkg::*;

  localparam longint               INC_FULL = baud_inc(longint'(CLK_HZ), longint'(BAUD),
                                                       longint'(OVERSAMPLE), ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] INC      = INC_FULL[ACC_WIDTH-1:0];
  localparam int CNT_W   = $clog2(OVERSAMPLE);
  localparam int IDX_W   = $clog2(DATA_BITS);
  localparam int GAP_MAX = GAP_BITS * OVERSAMPLE;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  logic                 tick;
  logic [1:0]           sync_q;
  logic [1:0]           hyst, hyst_nxt;
  logic                 filt;
  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W:0]       tick_idx;
  logic [IDX_W-1:0]     data_idx;
  logic                 stop_idx;
  logic                 sample_pt, bit_end, last_data, last_stop;
  logic                 clr_cnt, shift_en, par_en, stop_en, finish;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, stop_low, stop_high, done;
  logic                 par_x, par_calc;
  logic [GAP_W-1:0]     gap;
  logic                 idle_q;

  uart_baud_tick #(.ACC_WIDTH(ACC_WIDTH), .INC(INC)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    hyst_nxt = hyst;
    if (sync_q[1] && hyst != 2'd3)
      hyst_nxt = hyst + 2'd1;
    else if (!sync_q[1] && hyst != 2'd0)
      hyst_nxt = hyst - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      hyst   <= 2'd3;
      filt   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rxd};
      if (tick) begin
        hyst <= hyst_nxt;
        if (hyst_nxt == 2'd0)
          filt <= 1'b0;
        else if (hyst_nxt == 2'd3)
          filt <= 1'b1;
      end
    end
  end

  // The tick that enters a bit is index 0, so the next tick is bit_cnt+1.
  assign tick_idx  = {1'b0, bit_cnt} + 1'b1;
  assign sample_pt = tick && (tick_idx == (CNT_W+1)'(SAMPLE_TICK));
  assign bit_end   = tick && (tick_idx == (CNT_W+1)'(OVERSAMPLE));
  assign last_data = (data_idx == IDX_W'(DATA_BITS - 1));
  assign last_stop = (STOP_BITS == 1) || stop_idx;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (tick && !filt) state_nxt = ST_START;
      ST_START: begin
        if (sample_pt && filt)
          state_nxt = ST_IDLE;
        else if (bit_end)
          state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && last_data)
          state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY:    if (bit_end) state_nxt = ST_STOP;
      ST_STOP: begin
        if (sample_pt && last_stop)
          state_nxt = (stop_low || !filt) ? ST_WAIT_HIGH : ST_IDLE;
      end
      ST_WAIT_HIGH: if (tick && filt) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_cnt  = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE, ST_WAIT_HIGH: clr_cnt = 1'b1;
      ST_DATA:               shift_en = sample_pt;
      ST_PARITY:             par_en = sample_pt;
      ST_STOP: begin
        stop_en = sample_pt;
        finish  = sample_pt && last_stop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      data_idx  <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      stop_low  <= 1'b0;
      stop_high <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (clr_cnt) begin
        bit_cnt  <= '0;
        data_idx <= '0;
        stop_idx <= 1'b0;
      end else if (tick) begin
        bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
        if (bit_end && state == ST_DATA)
          data_idx <= data_idx + 1'b1;
        if (bit_end && state == ST_STOP)
          stop_idx <= 1'b1;
      end
      if (state == ST_IDLE) begin
        par_bit   <= 1'b0;
        stop_low  <= 1'b0;
        stop_high <= 1'b0;
      end
      if (shift_en)
        shreg <= {filt, shreg[DATA_BITS-1:1]};
      if (par_en)
        par_bit <= filt;
      if (stop_en) begin
        stop_low  <= stop_low | ~filt;
        stop_high <= stop_high | filt;
      end
    end
  end

  assign par_x = ^shreg ^ par_bit;

  always_comb begin
    par_calc = 1'b0;
    if (PARITY == PAR_ODD)
      par_calc = ~par_x;
    else if (PARITY == PAR_EVEN)
      par_calc = par_x;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ready <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      data_ready <= done;
      if (done) begin
        data       <= shreg;
        parity_err <= par_calc;
        frame_err  <= stop_low;
        break_det  <= (shreg == '0) && !par_bit && !stop_high;
      end
    end
  end

  // Gap counter starts saturated so reset reads as an already-idle line.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap    <= GAP_W'(GAP_MAX);
      idle_q <= 1'b1;
    end else begin
      idle_q <= idle;
      if (state != ST_IDLE)
        gap <= '0;
      else if (tick && gap != GAP_W'(GAP_MAX))
        gap <= gap + 1'b1;
    end
  end

  assign idle        = (gap >= GAP_W'(GAP_MAX));
  assign endofpacket = idle & ~idle_q;

endmodule
